// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: bundles the MEM-stage request/response handshake and the
// word-wide data memory bus of the load/store sequencer.
//   slave  : the sequencer (takes requests, drives responses and memory strobes)
//   master : the pipeline/memory side (drives requests and memory read data)
interface mem_access_unit_if #(parameter int ADDR_W = 7);
   logic              ReqValid;
   logic              ReqRead;
   logic              ReqWrite;
   logic [1:0]        ReqSize;
   logic              ReqSigned;
   logic [ADDR_W+1:0] ReqAddr;
   logic [31:0]       ReqWData;
   logic              Stall;
   logic              RespValid;
   logic [31:0]       RespData;
   logic              ReqErr;
   logic [ADDR_W-1:0] MemAddress;
   logic [31:0]       MemWriteData;
   logic              MemRead;
   logic              MemWrite;
   logic [31:0]       MemReadData;

   modport slave (
      input  ReqValid, ReqRead, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData, MemReadData,
      output Stall, RespValid, RespData, ReqErr, MemAddress, MemWriteData, MemRead, MemWrite
   );

   modport master (
      output ReqValid, ReqRead, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData, MemReadData,
      input  Stall, RespValid, RespData, ReqErr, MemAddress, MemWriteData, MemRead, MemWrite
   );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer between EX/MEM and a word-wide data memory.
// Turns byte-addressed lb/lbu/lh/lhu/lw/sb/sh/sw into word accesses; sub-word
// stores are read-modify-write. Stall is high whenever the FSM is not IDLE.
// Ports:
//   Clk   : clock, rising edge
//   Reset : synchronous, active-high
//   bus   : mem_access_unit_if.slave (request, response, memory strobes/data)
module mem_access_unit #(
   parameter int ADDR_W = 7
) (
   input logic              Clk,
   input logic              Reset,
   mem_access_unit_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RD   = 2'd1;
   localparam logic [1:0] WR   = 2'd2;

   logic [1:0]        state;
   logic              rRead, rSigned;
   logic [1:0]        rSize, rOff;
   logic [31:0]       rWData;
   logic [ADDR_W-1:0] memAddr;
   logic [31:0]       memWData, respData;
   logic              respValid, reqErr;

   logic              reqBad;
   logic [7:0]        selByte;
   logic [15:0]       selHalf;
   logic [31:0]       loadVal, mergeVal;

   assign bus.Stall        = (state != IDLE);
   assign bus.MemRead      = (state == RD);
   // Gated by Reset so a reset landing on the WR cycle never writes.
   assign bus.MemWrite     = (state == WR) && !Reset;
   assign bus.MemAddress   = memAddr;
   assign bus.MemWriteData = memWData;
   assign bus.RespData     = respData;
   assign bus.RespValid    = respValid;
   assign bus.ReqErr       = reqErr;

   always_comb begin
      reqBad = (bus.ReqRead == bus.ReqWrite)
            || (bus.ReqSize == 2'b11)
            || (bus.ReqSize == 2'b01 && bus.ReqAddr[0])
            || (bus.ReqSize == 2'b10 && bus.ReqAddr[1:0] != 2'b00);
   end

   // Little-endian lane select: byte k at [8k+7:8k], half at offset 2 in [31:16].
   always_comb begin
      selByte = bus.MemReadData[{rOff, 3'b000} +: 8];
      selHalf = bus.MemReadData[{rOff[1], 4'b0000} +: 16];
      case (rSize)
         2'b00:   loadVal = {{24{rSigned & selByte[7]}}, selByte};
         2'b01:   loadVal = {{16{rSigned & selHalf[15]}}, selHalf};
         default: loadVal = bus.MemReadData;
      endcase
   end

   always_comb begin
      mergeVal = bus.MemReadData;
      if (rSize == 2'b00) mergeVal[{rOff, 3'b000} +: 8]     = rWData[7:0];
      else                mergeVal[{rOff[1], 4'b0000} +: 16] = rWData[15:0];
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= IDLE;
         rRead     <= 1'b0;
         rSigned   <= 1'b0;
         rSize     <= 2'b00;
         rOff      <= 2'b00;
         rWData    <= '0;
         memAddr   <= '0;
         memWData  <= '0;
         respData  <= '0;
         respValid <= 1'b0;
         reqErr    <= 1'b0;
      end else begin
         respValid <= 1'b0;
         reqErr    <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.ReqValid) begin
                  if (reqBad) begin
                     reqErr <= 1'b1;
                  end else begin
                     rRead   <= bus.ReqRead;
                     rSize   <= bus.ReqSize;
                     rSigned <= bus.ReqSigned;
                     rOff    <= bus.ReqAddr[1:0];
                     rWData  <= bus.ReqWData;
                     memAddr <= bus.ReqAddr[ADDR_W+1:2];
                     // Full-word stores skip the read; everything else reads first.
                     if (bus.ReqWrite && bus.ReqSize == 2'b10) begin
                        memWData <= bus.ReqWData;
                        state    <= WR;
                     end else begin
                        state <= RD;
                     end
                  end
               end
            end
            RD: begin
               if (rRead) begin
                  respData  <= loadVal;
                  respValid <= 1'b1;
                  state     <= IDLE;
               end else begin
                  memWData <= mergeVal;
                  state    <= WR;
               end
            end
            WR:      state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
